// File: rtl/ee354_move_issuer.sv
// Button front end for the 2048 game FSM: synchronize, debounce, prioritize and issue one-hot moves.
// Optional auto-repeat of a held single direction is enabled by defining AUTO_REPEAT_EN.
module ee354_move_issuer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BtnU,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       game_ready,
    input  logic       game_over,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       pending,
    output logic [7:0] move_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_ARMED    = 3'd2,
        S_ISSUE    = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if ((DEBOUNCE_CYCLES < 2) || (REPEAT_CYCLES < 2) ||
            (64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_params
            $error("ee354_move_issuer: DEBOUNCE_CYCLES/REPEAT_CYCLES must be >= 2 and fit in CNT_W");
        end
    endgenerate

    // Highest-priority pressed button wins: U > D > L > R (vector is {U,D,L,R}).
    function automatic logic [3:0] f_prio(input logic [3:0] v);
        logic [3:0] res;
        if (v[3]) begin
            res = 4'b1000;
        end else if (v[2]) begin
            res = 4'b0100;
        end else if (v[1]) begin
            res = 4'b0010;
        end else if (v[0]) begin
            res = 4'b0001;
        end else begin
            res = 4'b0000;
        end
        return res;
    endfunction

    state_t           r_state;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_cand;
    logic [3:0]       r_dir;
    logic [3:0]       r_cmd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic [7:0]       r_move_count;

    logic [3:0]       w_sb;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_sb      = r_sync2;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

`ifdef AUTO_REPEAT_EN
    localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] r_rpt;
    logic [RPT_W-1:0] w_rpt_inc;

    assign w_rpt_inc = r_rpt + RPT_W'(1);

    // Repeat timer: runs only while exactly the last issued direction is held in RELEASE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_rpt <= '0;
        end else if ((r_state == S_RELEASE) && (w_sb == r_dir) && (w_rpt_inc != RPT_LAST)) begin
            r_rpt <= w_rpt_inc;
        end else begin
            r_rpt <= '0;
        end
    end
`endif

    // Synchronizers, debounce counter and the move FSM with its registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= S_IDLE;
            r_sync1      <= 4'b0000;
            r_sync2      <= 4'b0000;
            r_cand       <= 4'b0000;
            r_dir        <= 4'b0000;
            r_cmd        <= 4'b0000;
            r_cnt        <= '0;
            r_pending    <= 1'b0;
            r_move_count <= 8'd0;
        end else begin
            r_sync1 <= {BtnU, BtnD, BtnL, BtnR};
            r_sync2 <= r_sync1;
            r_cmd   <= 4'b0000;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_sb != 4'b0000) begin
                        r_cand  <= w_sb;
                        r_state <= S_DEBOUNCE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DEBOUNCE: begin
                    if (w_sb != r_cand) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_cnt_inc == DB_LAST) begin
                        r_cnt     <= '0;
                        r_dir     <= f_prio(r_cand);
                        r_pending <= 1'b1;
                        r_state   <= S_ARMED;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                // A win/lose screen swallows the held move instead of issuing it.
                S_ARMED: begin
                    r_cnt <= '0;
                    if (game_over) begin
                        r_pending <= 1'b0;
                        r_state   <= S_RELEASE;
                    end else if (game_ready) begin
                        r_cmd        <= r_dir;
                        r_pending    <= 1'b0;
                        r_move_count <= r_move_count + 8'd1;
                        r_state      <= S_ISSUE;
                    end else begin
                        r_state <= S_ARMED;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (w_sb != 4'b0000) begin
                        r_cnt <= '0;
`ifdef AUTO_REPEAT_EN
                        if ((w_sb == r_dir) && (w_rpt_inc == RPT_LAST)) begin
                            r_pending <= 1'b1;
                            r_state   <= S_ARMED;
                        end else begin
                            r_state <= S_RELEASE;
                        end
`else
                        r_state <= S_RELEASE;
`endif
                    end else if (w_cnt_inc == DB_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_cnt     <= '0;
                    r_pending <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign up         = r_cmd[3];
    assign down       = r_cmd[2];
    assign left       = r_cmd[1];
    assign right      = r_cmd[0];
    assign pending    = r_pending;
    assign move_count = r_move_count;

endmodule

// File: tb/tb_ee354_move_issuer.sv
// Scoreboard bench for ee354_move_issuer with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
module tb_ee354_move_issuer;

    localparam int DB = 4;
    localparam int RP = 10;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0;
    logic       game_ready = 1'b0, game_over = 1'b0;
    logic       up, down, left, right, pending;
    logic [7:0] move_count;

    typedef struct {
        logic [3:0] dir;
        int         at;
        logic [7:0] cnt;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         p;
    logic [7:0] exp_count = 8'd0;

    ee354_move_issuer #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(3),
        .REPEAT_CYCLES(RP)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
        .game_ready(game_ready), .game_over(game_over),
        .up(up), .down(down), .left(left), .right(right),
        .pending(pending), .move_count(move_count)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic expect_pulse(input logic [3:0] d, input int at);
        exp_t e;
        exp_count = exp_count + 8'd1;
        e.dir = d;
        e.at  = at;
        e.cnt = exp_count;
        q.push_back(e);
    endtask

    // Monitor: every direction pulse must match the next scoreboard entry.
    always @(negedge Clk) begin
        if ((Reset === 1'b1) && ((up | down | left | right) !== 1'b0)) begin
            exp_t e;
            check("pulse_onehot", $countones({up, down, left, right}), 1);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=%b required=none (cycle %0d)", {up, down, left, right}, cyc);
            end else begin
                e = q.pop_front();
                check("pulse_dir", {28'd0, up, down, left, right}, {28'd0, e.dir});
                check("pulse_cycle", cyc, e.at);
                check("pulse_count", {24'd0, move_count}, {24'd0, e.cnt});
                check("pulse_pending", {31'd0, pending}, 32'd0);
            end
        end
    end

    initial begin
        tick(2);
        check("rst_outputs", {27'd0, up, down, left, right, pending}, 32'd0);
        check("rst_count", {24'd0, move_count}, 32'd0);
        Reset = 1'b1;
        tick(3);
        check("idle_pending", {31'd0, pending}, 32'd0);

        // Left held 20 cycles: single pulse 7 cycles after the press.
        game_ready = 1'b1;
        BtnL = 1'b1;
        p = cyc;
        expect_pulse(4'b0010, p + 7);
`ifdef AUTO_REPEAT_EN
        expect_pulse(4'b0010, p + 18);
`endif
        tick(20);
        BtnL = 1'b0;
        tick(12);
        check("count_after_left", {24'd0, move_count}, {24'd0, exp_count});

        // Simultaneous U and R: up wins.
        BtnU = 1'b1;
        BtnR = 1'b1;
        p = cyc;
        expect_pulse(4'b1000, p + 7);
        tick(10);
        BtnU = 1'b0;
        BtnR = 1'b0;
        tick(8);

        // Down held while the game is busy; released before game_ready.
        game_ready = 1'b0;
        BtnD = 1'b1;
        p = cyc;
        tick(3);
        check("pend_early", {31'd0, pending}, 32'd0);
        tick(3);
        check("pend_at_6", {31'd0, pending}, 32'd1);
        tick(4);
        BtnD = 1'b0;
        check("pend_at_10", {31'd0, pending}, 32'd1);
        tick(10);
        check("pend_at_20", {31'd0, pending}, 32'd1);
        tick(10);
        check("pend_at_30", {31'd0, pending}, 32'd1);
        expect_pulse(4'b0100, p + 31);
        game_ready = 1'b1;
        tick(2);
        check("pend_after_issue", {31'd0, pending}, 32'd0);
        tick(8);

        // Short glitches on R never debounce.
        for (int i = 0; i < 4; i++) begin
            BtnR = 1'b1;
            tick(2);
            BtnR = 1'b0;
            tick(3);
            check("glitch_pending", {31'd0, pending}, 32'd0);
        end
        tick(5);
        check("count_after_glitch", {24'd0, move_count}, {24'd0, exp_count});

        // game_over while ARMED drops the move.
        game_ready = 1'b0;
        BtnR = 1'b1;
        p = cyc;
        tick(8);
        check("over_pend_armed", {31'd0, pending}, 32'd1);
        game_over = 1'b1;
        tick(2);
        check("over_pend_cleared", {31'd0, pending}, 32'd0);
        BtnR = 1'b0;
        game_over = 1'b0;
        game_ready = 1'b1;
        tick(12);
        check("count_after_over", {24'd0, move_count}, {24'd0, exp_count});

        // Up held 36 cycles: one pulse, or three with auto-repeat.
        BtnU = 1'b1;
        p = cyc;
        expect_pulse(4'b1000, p + 7);
`ifdef AUTO_REPEAT_EN
        expect_pulse(4'b1000, p + 18);
        expect_pulse(4'b1000, p + 29);
`endif
        tick(36);
        BtnU = 1'b0;
        tick(12);
        check("count_after_hold", {24'd0, move_count}, {24'd0, exp_count});

        // Reset in the ARMED cycle with game_ready high: nothing issues.
        BtnU = 1'b1;
        p = cyc;
        tick(6);
        check("rst_armed_pending", {31'd0, pending}, 32'd1);
        Reset = 1'b0;
        #1;
        check("rst_mid_outputs", {27'd0, up, down, left, right, pending}, 32'd0);
        check("rst_mid_count", {24'd0, move_count}, 32'd0);
        BtnU = 1'b0;
        exp_count = 8'd0;
        tick(3);
        Reset = 1'b1;
        tick(30);
        check("post_rst_count", {24'd0, move_count}, 32'd0);
        check("post_rst_pending", {31'd0, pending}, 32'd0);

        check("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
